// File: rtl/xc_aes_pkg.sv
// xc_aes_pkg: shared AES mix constants, FSM encoding and GF(2^8) helpers
package xc_aes_pkg;
   localparam int COLW = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   // multiply by a 4-bit constant as a sum of a, 2a, 4a, 8a
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2, a4, a8;
      a2 = xt(a);
      a4 = xt(a2);
      a8 = xt(a4);
      return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
   endfunction
endpackage

// File: rtl/xc_aesmix.sv
// xc_aesmix: single-cycle combinational AES (Inv)MixColumns on one column
//  valid in 1, rs1/rs2 in 32 (bytes 0,1 from rs1, bytes 2,3 from rs2),
//  enc in 1 (1 = MixColumns), ready out 1, result out 32
module xc_aesmix
   import xc_aes_pkg::*;
(
   input  logic            valid,
   input  logic [COLW-1:0] rs1,
   input  logic [COLW-1:0] rs2,
   input  logic            enc,
   output logic            ready,
   output logic [COLW-1:0] result
);
   logic [7:0] b0, b1, b2, b3;
   logic       unused_bits;
   // one output byte: coefficients rotate across the column
   function automatic logic [7:0] row(input logic [7:0] a, b, c, d, input logic e);
      return e ? (gmul(a, 4'd2) ^ gmul(b, 4'd3) ^ c ^ d)
               : (gmul(a, 4'd14) ^ gmul(b, 4'd11) ^ gmul(c, 4'd13) ^ gmul(d, 4'd9));
   endfunction
   assign b0 = rs1[7:0];
   assign b1 = rs1[15:8];
   assign b2 = rs2[23:16];
   assign b3 = rs2[31:24];
   assign unused_bits = ^{rs1[31:16], rs2[15:0]};
   assign ready = valid;
   assign result = {row(b3, b0, b1, b2, enc), row(b2, b3, b0, b1, enc),
                    row(b1, b2, b3, b0, enc), row(b0, b1, b2, b3, enc)};
endmodule

// File: rtl/xc_aesmix_seq.sv
// xc_aesmix_seq: streams an AES state one column per cycle through one xc_aesmix
//  clock/reset (async active-low), req_valid/req_ready/req_enc/req_data in,
//  rsp_valid/rsp_ready/rsp_data out, flush (sync abort), busy (BUSY or DONE)
module xc_aesmix_seq
   import xc_aes_pkg::*;
#(
   parameter  int NCOLS = 4,
   localparam int W     = COLW * NCOLS
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_enc,
   input  logic [W-1:0] req_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   input  logic         flush,
   output logic         busy
);
   localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   state_t          st, st_nxt;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    src;
   logic            enc_q;
   logic [COLW-1:0] col, mix_rs, mix_res;
   logic            mix_valid, last, unused_ready;
   logic [NCOLS-1:0] col_we;
   assign last = cnt == CW'(NCOLS - 1);
   always_ff @(posedge clock or negedge reset)
      if (!reset) st <= IDLE;
      else        st <= st_nxt;
   always_comb
      st_nxt = flush                       ? IDLE :
               (st == IDLE && req_valid)   ? BUSY :
               (st == BUSY && last)        ? DONE :
               (st == DONE && rsp_ready)   ? IDLE : st;
   always_comb begin
      req_ready = st == IDLE;
      rsp_valid = st == DONE;
      busy      = st == BUSY || st == DONE;
      mix_valid = st == BUSY;
   end
   always_comb begin
      col    = '0;
      col_we = '0;
      for (int c = 0; c < NCOLS; c++) begin
         if (cnt == CW'(c)) col = src[c*COLW +: COLW];
         col_we[c] = mix_valid && cnt == CW'(c);
      end
   end
   // operands held at zero outside BUSY so the mix logic stays quiet
   assign mix_rs = mix_valid ? col : '0;
   xc_aesmix u_mix (
      .valid  (mix_valid),
      .rs1    (mix_rs),
      .rs2    (mix_rs),
      .enc    (enc_q),
      .ready  (unused_ready),
      .result (mix_res)
   );
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cnt      <= '0;
         src      <= '0;
         enc_q    <= 1'b0;
         rsp_data <= '0;
      end else if (flush) begin
         cnt      <= '0;
         rsp_data <= '0;
      end else begin
         if (req_ready && req_valid) begin
            src   <= req_data;
            enc_q <= req_enc;
            cnt   <= '0;
         end
         if (mix_valid) cnt <= last ? cnt : cnt + 1'b1;
         for (int c = 0; c < NCOLS; c++)
            if (col_we[c]) rsp_data[c*COLW +: COLW] <= mix_res;
      end
endmodule

// File: tb/tb_xc_aesmix_seq.sv
// tb_xc_aesmix_seq: directed vectors for the AES mix sequencer (NCOLS=4 and NCOLS=1)
module tb_xc_aesmix_seq;
   import xc_aes_pkg::*;
   logic         clock = 0, reset = 0;
   logic         req_valid = 0, req_enc = 0, rsp_ready = 1, flush = 0;
   logic [127:0] req_data = '0;
   logic         req_ready, rsp_valid, busy;
   logic [127:0] rsp_data;
   logic         a_valid = 0, a_enc = 0;
   logic [31:0]  a_data = '0;
   logic         a_ready, a_rsp_valid, a_busy;
   logic [31:0]  a_rsp;
   int           checks = 0, errors = 0;
   int           lat;
   logic [127:0] q, e, rnd;
   xc_aesmix_seq #(.NCOLS(4)) dut4 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_enc(req_enc), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .flush(flush), .busy(busy)
   );
   xc_aesmix_seq #(.NCOLS(1)) dut1 (
      .clock(clock), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
      .req_enc(a_enc), .req_data(a_data), .rsp_valid(a_rsp_valid), .rsp_ready(1'b1),
      .rsp_data(a_rsp), .flush(1'b0), .busy(a_busy)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic accept(input logic enc, input logic [127:0] d);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clock); #1; n++;
      end
      check("req_ready_wait", req_ready, 1);
      req_valid = 1; req_enc = enc; req_data = d;
      @(posedge clock); #1;
      req_valid = 0;
   endtask
   task automatic wait_rsp(output int l);
      l = 0;
      while (!rsp_valid && l < 20) begin
         @(posedge clock); #1; l++;
      end
   endtask
   task automatic run(input logic enc, input logic [127:0] d, output logic [127:0] r, output int l);
      accept(enc, d);
      wait_rsp(l);
      r = rsp_data;
   endtask
   always @(negedge clock)
      if (reset) begin
         if (dut4.st != BUSY) check("gate4", dut4.mix_rs, 0);
         if (dut1.st != BUSY) check("gate1", dut1.mix_rs, 0);
      end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      #3;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_data", rsp_data, 0);
      @(posedge clock); #1 reset = 1;
      check("rst_req_ready", req_ready, 1);
      // enc, identical columns
      run(1, {4{32'h455313db}}, q, lat);
      check("t1_data", q, {4{32'hbca14d8e}});
      check("t1_lat", lat, 4);
      check("t1_busy", busy, 1);
      // dec, distinct columns (col0 in low bits)
      run(0, {32'hc6c6c6c6, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e}, q, lat);
      check("t2_data", q, {32'hc6c6c6c6, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db});
      check("t2_lat", lat, 4);
      // back-pressure
      @(posedge clock); #1 rsp_ready = 0;
      run(1, {32'hc6c6c6c6, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db}, q, lat);
      check("t3_data", q, {32'hc6c6c6c6, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e});
      req_valid = 1; req_enc = 0; req_data = {4{32'h01010101}};
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         check("t3_hold_data", rsp_data, {32'hc6c6c6c6, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e});
         check("t3_hold_valid", rsp_valid, 1);
         check("t3_hold_ready", req_ready, 0);
      end
      rsp_ready = 1;
      @(posedge clock); #1;
      check("t3_rel_valid", rsp_valid, 0);
      check("t3_rel_busy", busy, 0);
      check("t3_rel_ready", req_ready, 1);
      @(posedge clock); #1;
      check("t3_second_taken", busy, 1);
      req_valid = 0;
      wait_rsp(lat);
      check("t3_second_lat", lat, 4);
      check("t3_second_data", rsp_data, {4{32'h01010101}});
      // flush at cnt=2
      accept(1, {4{32'h12345678}});
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("t4_cnt", dut4.cnt, 2);
      flush = 1; req_valid = 1; req_data = {4{32'hdeadbeef}};
      @(posedge clock); #1;
      flush = 0; req_valid = 0;
      check("t4_busy", busy, 0);
      check("t4_rsp_valid", rsp_valid, 0);
      check("t4_rsp_data", rsp_data, 0);
      check("t4_req_ready", req_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         check("t4_no_rsp", rsp_valid, 0);
         check("t4_not_taken", busy, 0);
      end
      run(1, {4{32'h01010101}}, q, lat);
      check("t4_next_data", q, {4{32'h01010101}});
      check("t4_next_lat", lat, 4);
      // async reset mid-BUSY
      accept(1, {4{32'hcafef00d}});
      @(posedge clock); #1;
      #2 reset = 0;
      #1;
      check("t5_rsp_valid", rsp_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_rsp_data", rsp_data, 0);
      @(posedge clock); #1 reset = 1;
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run(1, rnd, e, lat);
      check("t5_enc_lat", lat, 4);
      run(0, e, q, lat);
      check("t5_roundtrip", q, rnd);
      // NCOLS=1 build
      @(posedge clock); #1;
      a_valid = 1; a_enc = 1; a_data = 32'h455313db;
      @(posedge clock); #1 a_valid = 0;
      check("n1_busy", a_busy, 1);
      @(posedge clock); #1;
      check("n1_valid", a_rsp_valid, 1);
      check("n1_enc", a_rsp, 32'hbca14d8e);
      @(posedge clock); #1;
      check("n1_idle", a_rsp_valid, 0);
      a_valid = 1; a_enc = 0; a_data = 32'hbca14d8e;
      @(posedge clock); #1 a_valid = 0;
      @(posedge clock); #1;
      check("n1_dec", a_rsp, 32'h455313db);
      @(posedge clock); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
